// File: rtl/riscv_hazard_unit_pkg.sv
// Shared RISC-V pipeline constants: scoreboard entry layout, register
// address width, the "read from register file" forwarding select value,
// and the scoreboard hit test used by the hazard matchers.
`timescale 1ns/1ps

package riscv_constants;

    localparam int REG_ADDR_W = 5;

    // Forwarding select value meaning "take the operand from the register file".
    localparam int FWD_SEL_RF = 0;

    // One in-flight instruction as seen by the hazard unit.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  werf;
        logic                  is_load;
    } sb_entry_t;

    // True when an in-flight entry produces the value a source operand reads.
    // x0 is hard-wired to zero, so it never creates a dependency.
    function automatic logic sb_hit(
        input sb_entry_t             entry,
        input logic [REG_ADDR_W-1:0] src,
        input logic                  uses
    );
        return entry.valid && entry.werf && uses &&
               (entry.rd == src) && (entry.rd != '0);
    endfunction

endpackage

// File: rtl/riscv_hazard_match.sv
// Per-source dependency matcher. Scans the scoreboard from the youngest
// entry (stage 1) outwards and reports the first producer of the source.
// FWD_EN selects between forwarding behaviour (stall only on a load whose
// data is not yet forwardable, report its stage) and register-file-only
// behaviour (stall on any in-flight producer, select always 0).
`timescale 1ns/1ps

module riscv_hazard_match
    import riscv_constants::*;
#(
    parameter int NUM_STAGES       = 5,
    parameter int LOAD_READY_STAGE = 5,
    parameter bit FWD_EN           = 1'b0,
    parameter int SEL_W            = $clog2(NUM_STAGES + 1)
) (
    input  sb_entry_t [NUM_STAGES-1:0] sb_in,
    input  logic [REG_ADDR_W-1:0]      src_in,
    input  logic                       uses_in,
    output logic                       hazard_out,
    output logic [SEL_W-1:0]           sel_out
);

    logic             found;
    logic [SEL_W-1:0] k_sel;
    logic             young_ld;

    // Youngest-match priority search, then hazard/select per build mode.
    always_comb begin
        found      = 1'b0;
        k_sel      = SEL_W'(FWD_SEL_RF);
        young_ld   = 1'b0;
        hazard_out = 1'b0;
        sel_out    = SEL_W'(FWD_SEL_RF);
        for (int k = 1; k <= NUM_STAGES; k++) begin
            if (!found && sb_hit(sb_in[k-1], src_in, uses_in)) begin
                found    = 1'b1;
                k_sel    = SEL_W'(k);
                young_ld = sb_in[k-1].is_load;
            end
        end
        if (FWD_EN) begin
            // Non-load results are forwardable from stage 1; load data only
            // from LOAD_READY_STAGE onward.
            hazard_out = young_ld && (int'(k_sel) < LOAD_READY_STAGE);
            sel_out    = k_sel;
        end else begin
            // No bypass network: any in-flight producer must drain first.
            hazard_out = found;
            sel_out    = SEL_W'(FWD_SEL_RF);
        end
    end

endmodule

// File: rtl/riscv_hazard_unit.sv
// RISC-V pipeline hazard unit: tracks in-flight destinations in a
// scoreboard shift register, derives load-use / RAW stalls and forwarding
// selects for both ID sources, applies branch-redirect flushes, and keeps
// stall/flush performance counters.
// Build option: define RISCV_FORWARDING_EN to enable operand forwarding;
// without it the selects are tied to 0 and any in-flight producer stalls.
`timescale 1ns/1ps

module riscv_hazard_unit
    import riscv_constants::*;
#(
    parameter int NUM_STAGES       = 5,
    parameter int LOAD_READY_STAGE = 5,
    parameter int PERF_CNT_W       = 32
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              id_valid_in,
    input  logic [REG_ADDR_W-1:0]             id_rs1_in,
    input  logic [REG_ADDR_W-1:0]             id_rs2_in,
    input  logic                              id_uses_rs1_in,
    input  logic                              id_uses_rs2_in,
    input  logic [REG_ADDR_W-1:0]             id_rd_in,
    input  logic                              id_werf_in,
    input  logic                              id_is_load_in,
    input  logic                              ex_redirect_in,
    output logic                              stall_out,
    output logic                              ex_bubble_out,
    output logic                              id_flush_out,
    output logic [$clog2(NUM_STAGES+1)-1:0]   fwd_sel_a_out,
    output logic [$clog2(NUM_STAGES+1)-1:0]   fwd_sel_b_out,
    output logic [PERF_CNT_W-1:0]             stall_cnt_out,
    output logic [PERF_CNT_W-1:0]             flush_cnt_out
);

    localparam int SEL_W = $clog2(NUM_STAGES + 1);

`ifdef RISCV_FORWARDING_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    // sb_q[k-1] holds the instruction k stages past ID.
    sb_entry_t [NUM_STAGES-1:0] sb_q;
    sb_entry_t                  id_entry;

    logic             haz_a;
    logic             haz_b;
    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;

    riscv_hazard_match #(
        .NUM_STAGES       (NUM_STAGES),
        .LOAD_READY_STAGE (LOAD_READY_STAGE),
        .FWD_EN           (FWD_EN),
        .SEL_W            (SEL_W)
    ) u_match_rs1 (
        .sb_in      (sb_q),
        .src_in     (id_rs1_in),
        .uses_in    (id_uses_rs1_in),
        .hazard_out (haz_a),
        .sel_out    (sel_a)
    );

    riscv_hazard_match #(
        .NUM_STAGES       (NUM_STAGES),
        .LOAD_READY_STAGE (LOAD_READY_STAGE),
        .FWD_EN           (FWD_EN),
        .SEL_W            (SEL_W)
    ) u_match_rs2 (
        .sb_in      (sb_q),
        .src_in     (id_rs2_in),
        .uses_in    (id_uses_rs2_in),
        .hazard_out (haz_b),
        .sel_out    (sel_b)
    );

    // Entry the ID instruction becomes if it advances into EX this cycle.
    always_comb begin
        id_entry         = '0;
        id_entry.valid   = id_valid_in && !ex_bubble_out;
        id_entry.rd      = id_rd_in;
        id_entry.werf    = id_werf_in;
        id_entry.is_load = id_is_load_in;
    end

    // Hazard resolution: reset silences everything, a redirect outranks a
    // stall (the stalled ID instruction is on the wrong path anyway), and an
    // empty ID slot never hazards.
    always_comb begin
        stall_out     = 1'b0;
        ex_bubble_out = 1'b0;
        id_flush_out  = 1'b0;
        fwd_sel_a_out = SEL_W'(FWD_SEL_RF);
        fwd_sel_b_out = SEL_W'(FWD_SEL_RF);
        if (!rst_in) begin
            if (id_valid_in) begin
                fwd_sel_a_out = sel_a;
                fwd_sel_b_out = sel_b;
            end
            if (ex_redirect_in) begin
                id_flush_out  = 1'b1;
                ex_bubble_out = 1'b1;
            end else if (id_valid_in && (haz_a || haz_b)) begin
                stall_out     = 1'b1;
                ex_bubble_out = 1'b1;
            end
        end
    end

    // Scoreboard shift: ID (or a bubble) enters stage 1, the oldest entry drops off.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sb_q <= '0;
        end else begin
            sb_q[0] <= id_entry.valid ? id_entry : '0;
            for (int k = 1; k < NUM_STAGES; k++) begin
                sb_q[k] <= sb_q[k-1];
            end
        end
    end

    // Free-running performance counters; natural wrap modulo 2^PERF_CNT_W.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            stall_cnt_out <= '0;
            flush_cnt_out <= '0;
        end else begin
            stall_cnt_out <= stall_cnt_out + PERF_CNT_W'(stall_out);
            flush_cnt_out <= flush_cnt_out + PERF_CNT_W'(ex_redirect_in);
        end
    end

endmodule

// File: tb/tb_riscv_hazard_unit.sv
// Directed bench for riscv_hazard_unit. Each step drives one ID-stage
// instruction, queues the outputs expected for that cycle, and compares
// them mid-cycle. Expectations follow the build (RISCV_FORWARDING_EN or not).
`timescale 1ns/1ps

module tb_riscv_hazard_unit;

    localparam int NS  = 5;
    localparam int LRS = 5;
    localparam int CW  = 32;
    localparam int SW  = $clog2(NS + 1);

`ifdef RISCV_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          id_valid_in;
    logic [4:0]    id_rs1_in;
    logic [4:0]    id_rs2_in;
    logic          id_uses_rs1_in;
    logic          id_uses_rs2_in;
    logic [4:0]    id_rd_in;
    logic          id_werf_in;
    logic          id_is_load_in;
    logic          ex_redirect_in;
    logic          stall_out;
    logic          ex_bubble_out;
    logic          id_flush_out;
    logic [SW-1:0] fwd_sel_a_out;
    logic [SW-1:0] fwd_sel_b_out;
    logic [CW-1:0] stall_cnt_out;
    logic [CW-1:0] flush_cnt_out;

    riscv_hazard_unit #(
        .NUM_STAGES       (NS),
        .LOAD_READY_STAGE (LRS),
        .PERF_CNT_W       (CW)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .id_valid_in    (id_valid_in),
        .id_rs1_in      (id_rs1_in),
        .id_rs2_in      (id_rs2_in),
        .id_uses_rs1_in (id_uses_rs1_in),
        .id_uses_rs2_in (id_uses_rs2_in),
        .id_rd_in       (id_rd_in),
        .id_werf_in     (id_werf_in),
        .id_is_load_in  (id_is_load_in),
        .ex_redirect_in (ex_redirect_in),
        .stall_out      (stall_out),
        .ex_bubble_out  (ex_bubble_out),
        .id_flush_out   (id_flush_out),
        .fwd_sel_a_out  (fwd_sel_a_out),
        .fwd_sel_b_out  (fwd_sel_b_out),
        .stall_cnt_out  (stall_cnt_out),
        .flush_cnt_out  (flush_cnt_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        string         tag;
        logic          stall;
        logic          bubble;
        logic          flush;
        logic [SW-1:0] fa;
        logic [SW-1:0] fb;
        logic [CW-1:0] scnt;
        logic [CW-1:0] fcnt;
    } exp_t;

    exp_t          exp_q[$];
    int            n_vec = 0;
    int            n_bad = 0;
    logic [CW-1:0] exp_scnt = '0;
    logic [CW-1:0] exp_fcnt = '0;

    task automatic cmp(input string tag, input string fld, input logic [CW-1:0] obs,
                       input logic [CW-1:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, expv);
        end
    endtask

    // Queue the outputs expected this cycle; counters show the stalls and
    // flushes of earlier cycles only.
    task automatic push(input string tag, input logic st, input logic bub, input logic fl,
                        input int fa, input int fb);
        exp_t e;
        e.tag    = tag;
        e.stall  = st;
        e.bubble = bub;
        e.flush  = fl;
        e.fa     = SW'(fa);
        e.fb     = SW'(fb);
        e.scnt   = exp_scnt;
        e.fcnt   = exp_fcnt;
        exp_q.push_back(e);
        if (st) exp_scnt = exp_scnt + 1;
        if (fl) exp_fcnt = exp_fcnt + 1;
    endtask

    task automatic check();
        exp_t e;
        @(negedge clk_in);
        if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = exp_q.pop_front();
            cmp(e.tag, "stall",  CW'(stall_out),     CW'(e.stall));
            cmp(e.tag, "bubble", CW'(ex_bubble_out), CW'(e.bubble));
            cmp(e.tag, "flush",  CW'(id_flush_out),  CW'(e.flush));
            cmp(e.tag, "fsel_a", CW'(fwd_sel_a_out), CW'(e.fa));
            cmp(e.tag, "fsel_b", CW'(fwd_sel_b_out), CW'(e.fb));
            cmp(e.tag, "scnt",   stall_cnt_out,      e.scnt);
            cmp(e.tag, "fcnt",   flush_cnt_out,      e.fcnt);
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic step(input string tag, input logic v, input int rd, input int rs1, input int rs2,
                        input logic u1, input logic u2, input logic werf, input logic ld,
                        input logic redir, input logic e_st, input logic e_bub, input logic e_fl,
                        input int e_fa, input int e_fb);
        id_valid_in    = v;
        id_rd_in       = 5'(rd);
        id_rs1_in      = 5'(rs1);
        id_rs2_in      = 5'(rs2);
        id_uses_rs1_in = u1;
        id_uses_rs2_in = u2;
        id_werf_in     = werf;
        id_is_load_in  = ld;
        ex_redirect_in = redir;
        push(tag, e_st, e_bub, e_fl, e_fa, e_fb);
        check();
    endtask

    task automatic drain();
        for (int i = 0; i < NS; i++)
            step("drain", 1'b0, 0, 1, 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_st;

        // Reset: outputs and counters forced to 0 even with a redirect and a would-be hazard.
        rst_in = 1'b1;
        step("reset", 1'b1, 6, 5, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        rst_in = 1'b0;

        // ADD x5 ; ADD x6,x5 back-to-back.
        step("add_x5", 1'b1, 5, 1, 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        n_st = FWD ? 0 : NS;
        for (int i = 1; i <= n_st; i++)
            step("raw_stall", 1'b1, 6, 5, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
        step("raw_go", 1'b1, 6, 5, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, FWD ? 1 : 0, 0);
        // Invalid ID reading x6 right behind its producer: no hazard.
        step("id_invalid", 1'b0, 7, 6, 6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        drain();

        // LW x5 ; ADD x6,x5 load-use.
        step("lw_x5", 1'b1, 5, 2, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        n_st = FWD ? (LRS - 1) : NS;
        for (int i = 1; i <= n_st; i++)
            step("lu_stall", 1'b1, 6, 5, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
                 FWD ? i : 0, 0);
        step("lu_go", 1'b1, 6, 5, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
             FWD ? LRS : 0, 0);
        drain();

        // Source named but not read: no hazard.
        step("add_x5b", 1'b1, 5, 1, 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        step("no_use", 1'b1, 6, 5, 5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        drain();

        // ADD x0 ; ADD x6,x0,x0: x0 never hazards.
        step("add_x0", 1'b1, 0, 1, 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        step("use_x0", 1'b1, 6, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        drain();

        // Redirect during an active load-use stall.
        step("lw_x5r", 1'b1, 5, 2, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        step("rd_stall", 1'b1, 6, 5, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
             FWD ? 1 : 0, 0);
        step("redirect", 1'b1, 6, 5, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
             FWD ? 2 : 0, 0);
        // The flushed ADD x6 must not have entered stage 1.
        step("post_redir", 1'b1, 7, 6, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        drain();

        // LW x5 ; ADD x5 ; ADD x6,x5: youngest producer (the ADD) wins.
        step("lw_old", 1'b1, 5, 2, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        step("add_new", 1'b1, 5, 1, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        n_st = FWD ? 0 : NS;
        for (int i = 1; i <= n_st; i++)
            step("yng_stall", 1'b1, 6, 5, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
        step("yng_go", 1'b1, 6, 5, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, FWD ? 1 : 0, 0);
        drain();

        // ADD x8 ; ADD x9 ; ADD x10,x9,x8: both sources from different stages.
        step("add_x8", 1'b1, 8, 1, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        step("add_x9", 1'b1, 9, 1, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        for (int i = 1; i <= n_st; i++)
            step("ab_stall", 1'b1, 10, 9, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
        step("ab_go", 1'b1, 10, 9, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
             FWD ? 1 : 0, FWD ? 2 : 0);
        drain();

        // Reset pulsed mid-stall: everything clears at once, then an empty scoreboard.
        step("lw_x5s", 1'b1, 5, 2, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        step("pre_rst", 1'b1, 6, 5, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
             FWD ? 1 : 0, 0);
        rst_in   = 1'b1;
        exp_scnt = '0;
        exp_fcnt = '0;
        step("mid_rst", 1'b1, 6, 5, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        rst_in = 1'b0;
        step("post_rst", 1'b1, 6, 5, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/riscv_hazard_unit.md
RISCV_HAZARD_UNIT -- requirements
Module: riscv_hazard_unit

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 5, meaning in-flight stages tracked past ID (1=EX … 5=WB2).
REQ-002 SHALL have parameter LOAD_READY_STAGE, default 5, meaning the first stage at which load data is forwardable.
REQ-003 SHALL have parameter PERF_CNT_W, default 32, meaning the width of each performance counter.
REQ-004 SHALL have one clock and one reset: clk_in is the clock, and rst_in is the reset, asynchronous and active-high.
REQ-005 SHALL have port clk_in, input, width 1, system clock.
REQ-006 SHALL have port rst_in, input, width 1, asynchronous active-high reset.
REQ-007 SHALL have port id_valid_in, input, width 1, ID holds a real instruction.
REQ-008 SHALL have ports id_rs1_in and id_rs2_in, input, width 5 each, ID source registers.
REQ-009 SHALL have ports id_uses_rs1_in and id_uses_rs2_in, input, width 1 each, source actually read.
REQ-010 SHALL have port id_rd_in, input, width 5, ID destination register.
REQ-011 SHALL have port id_werf_in, input, width 1, ID writes the register file.
REQ-012 SHALL have port id_is_load_in, input, width 1, ID is a load.
REQ-013 SHALL have port ex_redirect_in, input, width 1, EX resolved a taken branch, JAL or JALR.
REQ-014 SHALL have port stall_out, input-free output, width 1, hold PC and ID.
REQ-015 SHALL have ports ex_bubble_out and id_flush_out, output, width 1 each: EX loads a NOP; ID loads a NOP.
REQ-016 SHALL have ports fwd_sel_a_out and fwd_sel_b_out, output, width $clog2(NUM_STAGES+1) each: 0 means register file, k means stage k result.
REQ-017 SHALL have ports stall_cnt_out and flush_cnt_out, output, width PERF_CNT_W each, performance counters.

Function
REQ-018 SHALL keep a scoreboard shift register of NUM_STAGES entries {valid, rd, werf, is_load}, where entry k is the instruction k stages past ID.
REQ-019 SHALL, every cycle, shift entry k to k+1, drop entry NUM_STAGES, and load entry 1 from ID when ID advances, or with an invalid entry on a bubble.
REQ-020 SHALL, for each source, define a match as a valid entry with werf=1, rd equal to the source, rd≠0, and uses_rsX=1; only the youngest (smallest k) match counts.
REQ-021 SHALL treat x0 as never hazarding.
REQ-022 SHALL, when forwarding is compiled in, set fwd_sel to k of the youngest match, or 0 if there is none.
REQ-023 SHALL, when forwarding is compiled in, assert stall_out and ex_bubble_out combinationally when the youngest match is a load with k < LOAD_READY_STAGE.
REQ-024 SHALL treat a non-load result as forwardable from stage 1.
REQ-025 SHALL give ex_redirect_in priority over stall: assert id_flush_out and ex_bubble_out and deassert stall_out in the same cycle, so that entry 1 next cycle is invalid.
REQ-026 SHALL clear hazards when the instruction in ID is invalid, i.e. id_valid_in=0 produces no hazard.
REQ-027 SHALL increment stall_cnt_out by 1 on each cycle with stall_out=1.
REQ-028 SHALL increment flush_cnt_out by 1 on each cycle with ex_redirect_in=1.
REQ-029 SHALL wrap both counters modulo 2^PERF_CNT_W.
REQ-030 SHALL let a stall persist until the load reaches LOAD_READY_STAGE; that is (LOAD_READY_STAGE−1) cycles for a load immediately followed by a dependent instruction.

Reset
REQ-031 SHALL, while rst_in=1, asynchronously invalidate all scoreboard entries.
REQ-032 SHALL, while rst_in=1, zero both counters and drive stall_out, ex_bubble_out, id_flush_out and both fwd_sel outputs to 0.
REQ-033 SHALL let reset asserted mid-stall abort the stall immediately, and resume normal operation from an empty scoreboard on the first edge after release.

Configuration
REQ-034 SHALL, with RISCV_FORWARDING_EN defined, behave per REQ-022 to REQ-024.
REQ-035 SHALL, without RISCV_FORWARDING_EN, tie fwd_sel outputs to 0.
REQ-036 SHALL, without RISCV_FORWARDING_EN, stall on any match in stages 1..NUM_STAGES (the register file is not write-through), with redirect priority unchanged.

Structure
REQ-037 SHALL place the scoreboard entry typedef and the FWD_SEL_RF=0 constant in the shared riscv_constants package.
REQ-038 SHALL implement the per-source match/priority logic as sub-module riscv_hazard_match, instantiated twice (rs1, rs2).

Verification
REQ-039 SHALL cover: ADD x5 then ADD x6,x5 back-to-back with forwarding -> fwd_sel_a=1, no stall.
REQ-040 SHALL cover: LW x5 then ADD x6,x5 with LOAD_READY_STAGE=5 -> 4 stall cycles, then fwd_sel_a=5, stall_cnt=4.
REQ-041 SHALL cover: ADD x0 then ADD x6,x0 -> fwd_sel=0, no stall.
REQ-042 SHALL cover: ex_redirect_in during an active load-use stall -> same cycle id_flush_out=1 and stall_out=0, flush_cnt=1.
REQ-043 SHALL cover: without RISCV_FORWARDING_EN, ADD x5 then ADD x6,x5 -> 5 stall cycles, fwd_sel always 0.
REQ-044 SHALL cover: rst_in pulsed mid-stall -> outputs 0 immediately, counters 0, next instruction issues without stall.
